seg7_matrix_scanner: RTL and testbench

Time-multiplexed display driver for the signed result matrix of the matrix-multiplier datapath. It takes a packed vector of N_ELEMS two's-complement elements of ELEM_W bits each. It captures the vector on a load strobe and scans one element per refresh slot onto a shared 7-segment bus, with a one-hot digit select and a per-digit sign indicator. The displayed snapshot changes only at frame boundaries, so a new result never tears across digits.

---
 rtl/seg7_matrix_scanner.sv | 187 ++++++++++++++++++
 tb/tb_seg7_matrix_scanner.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/seg7_matrix_scanner.sv
// seg7_matrix_scanner
// Time-multiplexed 7-segment driver for a packed vector of signed elements.
// A load captures the vector into a shadow register. The shadow is promoted
// to the display register only at a frame wrap, so a frame never mixes two
// results. Each element is shown in its own refresh slot. Each slot starts
// with a blanking window that suppresses ghosting.
// Optional build macro: NEG_BLINK_EN. When it is defined, a frame counter
// exists and negative digits blank their segments while frame_counter[3] is
// set. The sign indicator stays lit during those frames.
module seg7_matrix_scanner #(
  parameter int ELEM_W    = 4,
  parameter int N_ELEMS   = 4,
  parameter int SLOT_CYC  = 1024,
  parameter int BLANK_CYC = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_ELEMS*ELEM_W-1:0]   matrix_c,
  input  logic                        load,
  output logic [6:0]                  seg,
  output logic                        sign,
  output logic [N_ELEMS-1:0]          digit_sel,
  output logic                        frame_start,
  output logic                        pending
);

  localparam int VEC_W = N_ELEMS * ELEM_W;
  localparam int CNT_W = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
  localparam int IDX_W = (N_ELEMS > 1) ? $clog2(N_ELEMS) : 1;

  localparam logic [CNT_W-1:0]   LAST_CNT  = CNT_W'(SLOT_CYC - 1);
  localparam logic [CNT_W-1:0]   BLANK_CNT = CNT_W'(BLANK_CYC);
  localparam logic [CNT_W-1:0]   ZERO_CNT  = CNT_W'(0);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(N_ELEMS - 1);
  localparam logic [IDX_W-1:0]   ZERO_IDX  = IDX_W'(0);
  localparam logic [IDX_W-1:0]   ONE_IDX   = IDX_W'(1);
  localparam logic [N_ELEMS-1:0] SEL_ONE   = N_ELEMS'(1);

  // Magnitude-to-segment decode; magnitudes above 8 are outside the legal range.
  function automatic logic [6:0] seg_decode(input logic [4:0] mag);
    logic [6:0] pattern;
    case (mag)
      5'd0:    pattern = 7'b0111111;
      5'd1:    pattern = 7'b0000110;
      5'd2:    pattern = 7'b1011011;
      5'd3:    pattern = 7'b1001111;
      5'd4:    pattern = 7'b1100110;
      5'd5:    pattern = 7'b1101101;
      5'd6:    pattern = 7'b1111101;
      5'd7:    pattern = 7'b0000111;
      5'd8:    pattern = 7'b1111111;
      default: pattern = 7'b0000000;
    endcase
    return pattern;
  endfunction

  logic [VEC_W-1:0]   shadow_r;
  logic [VEC_W-1:0]   disp_r;
  logic               pending_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [IDX_W-1:0]   idx_r;
  logic [6:0]         seg_r;
  logic               sign_r;
  logic [N_ELEMS-1:0] sel_r;
  logic               fs_r;
`ifdef NEG_BLINK_EN
  logic [3:0]         frame_cnt_r;
`endif

  logic               slot_end_s;
  logic               frame_wrap_s;
  logic               blank_s;
  logic [ELEM_W-1:0]  elem_s;
  logic               neg_s;
  logic [ELEM_W:0]    ext_s;
  logic [ELEM_W:0]    mag_s;
  logic [4:0]         mag5_s;
  logic [6:0]         seg_val_s;

  assign slot_end_s   = (cnt_r == LAST_CNT);
  assign frame_wrap_s = slot_end_s && (idx_r == LAST_IDX);
  assign blank_s      = (cnt_r < BLANK_CNT);

  // Select the current element and form its segment pattern from |element|.
  always_comb begin
    elem_s    = disp_r[int'(idx_r)*ELEM_W +: ELEM_W];
    neg_s     = elem_s[ELEM_W-1];
    ext_s     = {elem_s[ELEM_W-1], elem_s};
    mag_s     = ext_s;
    mag5_s    = 5'd0;
    seg_val_s = 7'b0000000;
    // One extra bit so the most negative value keeps its full magnitude.
    if (neg_s) begin
      mag_s = (~ext_s) + {{ELEM_W{1'b0}}, 1'b1};
    end else begin
      mag_s = ext_s;
    end
    mag5_s[ELEM_W:0] = mag_s;
`ifdef NEG_BLINK_EN
    if (neg_s && frame_cnt_r[3]) begin
      seg_val_s = 7'b0000000;
    end else begin
      seg_val_s = seg_decode(mag5_s);
    end
`else
    seg_val_s = seg_decode(mag5_s);
`endif
  end

  // Slot cycle counter and digit index; the index advances once per slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= ZERO_CNT;
      idx_r <= ZERO_IDX;
    end else if (slot_end_s) begin
      cnt_r <= ZERO_CNT;
      if (idx_r == LAST_IDX) begin
        idx_r <= ZERO_IDX;
      end else begin
        idx_r <= idx_r + ONE_IDX;
      end
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Shadow capture and the pending flag; a load that coincides with a wrap keeps pending set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_r  <= {VEC_W{1'b0}};
      pending_r <= 1'b0;
    end else if (load) begin
      shadow_r  <= matrix_c;
      pending_r <= 1'b1;
    end else if (frame_wrap_s) begin
      pending_r <= 1'b0;
    end
  end

  // Promote the shadow to the display register only at a frame wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_r <= {VEC_W{1'b0}};
    end else if (frame_wrap_s && pending_r) begin
      disp_r <= shadow_r;
    end
  end

`ifdef NEG_BLINK_EN
  // Frame counter that sets the blink phase of negative digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_r <= 4'd0;
    end else if (frame_wrap_s) begin
      frame_cnt_r <= frame_cnt_r + 4'd1;
    end
  end
`endif

  // Registered display outputs, blanked at the start of every slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_r  <= 7'b0000000;
      sign_r <= 1'b0;
      sel_r  <= {N_ELEMS{1'b0}};
      fs_r   <= 1'b0;
    end else begin
      fs_r <= (cnt_r == ZERO_CNT) && (idx_r == ZERO_IDX);
      if (blank_s) begin
        seg_r  <= 7'b0000000;
        sign_r <= 1'b0;
        sel_r  <= {N_ELEMS{1'b0}};
      end else begin
        seg_r  <= seg_val_s;
        sign_r <= neg_s;
        sel_r  <= SEL_ONE << idx_r;
      end
    end
  end

  assign seg         = seg_r;
  assign sign        = sign_r;
  assign digit_sel   = sel_r;
  assign frame_start = fs_r;
  assign pending     = pending_r;

endmodule

// File: tb/tb_seg7_matrix_scanner.sv
// Directed bench for seg7_matrix_scanner with default parameters.
// pos counts clock edges since the edge that shows frame_start for frame 0.
// The outputs at pos p reflect slot/counter position p inside the frame.
module tb_seg7_matrix_scanner;

  localparam int SLOT  = 1024;
  localparam int FRAME = 4 * SLOT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] matrix_c = 16'h0000;
  logic        load = 1'b0;
  logic [6:0]  seg;
  logic        sign;
  logic [3:0]  digit_sel;
  logic        frame_start;
  logic        pending;

  int checks = 0;
  int failures = 0;
  int pos = 0;

  seg7_matrix_scanner dut (
    .clk(clk),
    .rst_n(rst_n),
    .matrix_c(matrix_c),
    .load(load),
    .seg(seg),
    .sign(sign),
    .digit_sel(digit_sel),
    .frame_start(frame_start),
    .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    pos++;
  endtask

  task automatic goto_pos(input int f, input int s, input int c);
    int target;
    target = f * FRAME + s * SLOT + c;
    while (pos < target) step();
  endtask

  task automatic pulse_load(input logic [15:0] v);
    load = 1'b1;
    matrix_c = v;
    step();
    load = 1'b0;
  endtask

  task automatic check_digit(input string tag, input int f, input int s,
                             input logic [6:0] exp_seg, input logic exp_sign);
    goto_pos(f, s, 20);
    check_val({tag, "_seg"}, 32'(seg), 32'(exp_seg));
    check_val({tag, "_sign"}, 32'(sign), 32'(exp_sign));
    check_val({tag, "_sel"}, 32'(digit_sel), 32'd1 << s);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    pos = 0;
    check_val("rel_frame_start", 32'(frame_start), 32'd1);
    check_val("rel_pending", 32'(pending), 32'd0);
  endtask

  initial begin
    // Outputs held at zero while in reset.
    #12;
    check_val("rst_seg", 32'(seg), 32'd0);
    check_val("rst_sign", 32'(sign), 32'd0);
    check_val("rst_sel", 32'(digit_sel), 32'd0);
    check_val("rst_fs", 32'(frame_start), 32'd0);
    check_val("rst_pending", 32'(pending), 32'd0);
    release_reset();

    // Idle scan of a zero display.
    step();
    check_val("fs_one_cycle", 32'(frame_start), 32'd0);
    goto_pos(0, 0, 15);
    check_val("blank_last_sel", 32'(digit_sel), 32'd0);
    check_val("blank_last_seg", 32'(seg), 32'd0);
    goto_pos(0, 0, 16);
    check_val("first_lit_sel", 32'(digit_sel), 32'd1);
    check_val("first_lit_seg", 32'(seg), 32'h3F);
    check_val("first_lit_sign", 32'(sign), 32'd0);
    for (int s = 1; s < 4; s++) check_digit("idle", 0, s, 7'b0111111, 1'b0);

    // Load 8F31: elements 1, 3, -1, -8.
    goto_pos(0, 3, 100);
    pulse_load(16'h8F31);
    check_val("load_pending", 32'(pending), 32'd1);
    goto_pos(0, 3, 1022);
    check_val("pre_wrap_pending", 32'(pending), 32'd1);
    goto_pos(0, 3, 1023);
    check_val("wrap_pending_clr", 32'(pending), 32'd0);
    goto_pos(1, 0, 0);
    check_val("f1_frame_start", 32'(frame_start), 32'd1);

    // Frame 1 shows 8F31; two loads land in the shadow and do not tear the frame.
    check_digit("v_d0", 1, 0, 7'b0000110, 1'b0);
    goto_pos(1, 0, 200);
    pulse_load(16'h1111);
    check_digit("v_d1", 1, 1, 7'b1001111, 1'b0);
    goto_pos(1, 1, 200);
    pulse_load(16'h2222);
    check_val("dbl_pending", 32'(pending), 32'd1);
    check_digit("v_d2", 1, 2, 7'b0000110, 1'b1);
    check_digit("v_d3", 1, 3, 7'b1111111, 1'b1);

    // Frame 2: last load wins.
    for (int s = 0; s < 4; s++) check_digit("last_wins", 2, s, 7'b1011011, 1'b0);

    // Load 7777 mid-frame, then 3333 exactly on the wrap edge.
    goto_pos(2, 1, 300);
    pulse_load(16'h7777);
    goto_pos(2, 3, 1022);
    pulse_load(16'h3333);
    check_val("wrap_load_pending", 32'(pending), 32'd1);
    for (int s = 0; s < 4; s++) check_digit("wrap_old", 3, s, 7'b0000111, 1'b0);
    goto_pos(3, 3, 1000);
    check_val("wrap_still_pending", 32'(pending), 32'd1);
    goto_pos(3, 3, 1023);
    check_val("wrap2_pending_clr", 32'(pending), 32'd0);
    for (int s = 0; s < 4; s++) check_digit("wrap_new", 4, s, 7'b1001111, 1'b0);

    // Asynchronous reset mid-slot 2 with a load pending.
    goto_pos(4, 2, 400);
    pulse_load(16'hCCCC);
    check_val("pre_rst_pending", 32'(pending), 32'd1);
    goto_pos(4, 2, 500);
    check_val("pre_rst_seg", 32'(seg), 32'h4F);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("async_seg", 32'(seg), 32'd0);
    check_val("async_sel", 32'(digit_sel), 32'd0);
    check_val("async_sign", 32'(sign), 32'd0);
    check_val("async_pending", 32'(pending), 32'd0);
    repeat (3) @(posedge clk);
    release_reset();
    for (int s = 0; s < 4; s++) check_digit("post_rst", 0, s, 7'b0111111, 1'b0);
    goto_pos(0, 3, 1023);
    check_val("post_rst_pending", 32'(pending), 32'd0);
    check_digit("discarded", 1, 0, 7'b0111111, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
